// File: rtl/arb_pkg.sv
// Shared arbiter/shaper parameters and helpers, so both sides agree on requester count and burst length.
package arb_pkg;

    localparam int unsigned DEF_NUM_REQUESTS  = 4;
    localparam int unsigned DEF_NUM_CLK_GRANT = 4;
    localparam int unsigned DEF_MAX_PENDING   = 7;

    typedef logic [DEF_NUM_REQUESTS-1:0] req_vec_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_req_lane.sv
// One requester's pending-transaction counter, grant-burst beat counter, completion pulse and sticky errors.
module arb_req_lane
    import arb_pkg::*;
#(
    parameter int unsigned NUM_CLK_GRANT = DEF_NUM_CLK_GRANT,
    parameter int unsigned MAX_PENDING   = DEF_MAX_PENDING
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic grant,
    input  logic clear_err,
    output logic req,
    output logic full,
    output logic done,
    output logic overflow_err,
    output logic spurious_err
);

    localparam int unsigned PEND_W = cnt_width(MAX_PENDING + 1);
    localparam int unsigned BEAT_W = cnt_width(NUM_CLK_GRANT);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_CLK_GRANT - 1);

    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_next;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_next;
    logic              hit;
    logic              complete;
    logic              overflow_next;
    logic              spurious_next;

    // Next-state: a grant only counts while req is up; a push and a completion in one cycle cancel out.
    always_comb begin
        hit           = grant & req;
        complete      = hit && (beat == BEAT_LAST);
        beat_next     = '0;
        pend_next     = pend;
        overflow_next = overflow_err & ~clear_err;
        spurious_next = (spurious_err & ~clear_err) | (grant & ~req);

        if (hit && !complete) begin
            beat_next = beat + BEAT_W'(1);
        end

        if (push && !complete) begin
            if (full) begin
                overflow_next = 1'b1;
            end else begin
                pend_next = pend + PEND_W'(1);
            end
        end else if (!push && complete) begin
            pend_next = pend - PEND_W'(1);
        end
    end

    // req/full are registered from the next pend value so they never see inputs combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend         <= '0;
            beat         <= '0;
            req          <= 1'b0;
            full         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            pend         <= pend_next;
            beat         <= beat_next;
            req          <= (pend_next != '0);
            full         <= (pend_next == PEND_MAX);
            done         <= complete;
            overflow_err <= overflow_next;
            spurious_err <= spurious_next;
        end
    end

endmodule

// File: rtl/arb_req_shaper.sv
// Turns per-requester push pulses into held level requests for the round-robin arbiter.
module arb_req_shaper
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQUESTS  = DEF_NUM_REQUESTS,
    parameter int unsigned NUM_CLK_GRANT = DEF_NUM_CLK_GRANT,
    parameter int unsigned MAX_PENDING   = DEF_MAX_PENDING
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQUESTS-1:0] push,
    input  logic [NUM_REQUESTS-1:0] grant,
    input  logic                    clear_err,
    output logic [NUM_REQUESTS-1:0] req,
    output logic [NUM_REQUESTS-1:0] full,
    output logic [NUM_REQUESTS-1:0] done,
    output logic [NUM_REQUESTS-1:0] overflow_err,
    output logic [NUM_REQUESTS-1:0] spurious_err
);

    for (genvar i = 0; i < NUM_REQUESTS; i++) begin : g_lane
        arb_req_lane #(
            .NUM_CLK_GRANT (NUM_CLK_GRANT),
            .MAX_PENDING   (MAX_PENDING)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .push         (push[i]),
            .grant        (grant[i]),
            .clear_err    (clear_err),
            .req          (req[i]),
            .full         (full[i]),
            .done         (done[i]),
            .overflow_err (overflow_err[i]),
            .spurious_err (spurious_err[i])
        );
    end

endmodule

// File: tb/tb_arb_req_shaper.sv
// Directed bench for arb_req_shaper; the bench itself plays the round-robin arbiter in the last scenario.
module tb_arb_req_shaper;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] push;
    logic [3:0] grant;
    logic       clear_err;
    logic [3:0] req;
    logic [3:0] full;
    logic [3:0] done;
    logic [3:0] overflow_err;
    logic [3:0] spurious_err;

    int checks   = 0;
    int failures = 0;

    arb_req_shaper #(
        .NUM_REQUESTS  (4),
        .NUM_CLK_GRANT (4),
        .MAX_PENDING   (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .grant        (grant),
        .clear_err    (clear_err),
        .req          (req),
        .full         (full),
        .done         (done),
        .overflow_err (overflow_err),
        .spurious_err (spurious_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic [3:0] p, input logic [3:0] g, input logic c);
        push      = p;
        grant     = g;
        clear_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},  32'(req),          32'h0);
        check({tag, "_full"}, 32'(full),         32'h0);
        check({tag, "_done"}, 32'(done),         32'h0);
        check({tag, "_ovf"},  32'(overflow_err), 32'h0);
        check({tag, "_spur"}, 32'(spurious_err), 32'h0);
    endtask

    initial begin
        int dcount;
        int owner;
        int ptr;

        reset = 1'b1;
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        check_all_zero("reset");
        reset = 1'b0;

        // 1: single push, one full burst
        step(4'b0010, 4'b0000, 1'b0);
        check("t1_req_after_push", 32'(req), 32'h2);
        for (int b = 0; b < 4; b++) begin
            step(4'b0000, 4'b0010, 1'b0);
            check("t1_done", 32'(done), (b == 3) ? 32'h2 : 32'h0);
            check("t1_req",  32'(req),  (b == 3) ? 32'h0 : 32'h2);
        end
        step(4'b0000, 4'b0000, 1'b0);
        check("t1_done_one_cycle", 32'(done), 32'h0);

        // 2: three queued transactions drained by a held grant
        for (int k = 0; k < 3; k++) step(4'b0001, 4'b0000, 1'b0);
        check("t2_req", 32'(req), 32'h1);
        for (int b = 1; b <= 12; b++) begin
            step(4'b0000, 4'b0001, 1'b0);
            check("t2_done", 32'(done), (b % 4 == 0) ? 32'h1 : 32'h0);
            check("t2_req",  32'(req),  (b == 12) ? 32'h0 : 32'h1);
        end
        step(4'b0000, 4'b0000, 1'b0);

        // 3: fill requester 2, overflow, push on final beat, drain
        for (int k = 1; k <= 7; k++) begin
            step(4'b0100, 4'b0000, 1'b0);
            check("t3_full", 32'(full), (k == 7) ? 32'h4 : 32'h0);
        end
        step(4'b0100, 4'b0000, 1'b0);
        check("t3_ovf_set",  32'(overflow_err), 32'h4);
        check("t3_full_ovf", 32'(full),         32'h4);
        step(4'b0000, 4'b0000, 1'b1);
        check("t3_ovf_clr",  32'(overflow_err), 32'h0);
        for (int b = 0; b < 3; b++) step(4'b0000, 4'b0100, 1'b0);
        step(4'b0100, 4'b0100, 1'b0);
        check("t3_last_beat_done", 32'(done),         32'h4);
        check("t3_last_beat_full", 32'(full),         32'h4);
        check("t3_last_beat_ovf",  32'(overflow_err), 32'h0);
        dcount = 0;
        for (int b = 1; b <= 28; b++) begin
            step(4'b0000, 4'b0100, 1'b0);
            if (done[2]) dcount++;
            if (b == 4) check("t3_full_drop", 32'(full), 32'h0);
        end
        check("t3_drain_count", 32'(dcount), 32'd7);
        check("t3_req_end",     32'(req),    32'h0);
        check("t3_spur",        32'(spurious_err), 32'h0);
        step(4'b0000, 4'b0000, 1'b0);

        // 4: interrupted burst is discarded
        step(4'b1000, 4'b0000, 1'b0);
        dcount = 0;
        step(4'b0000, 4'b1000, 1'b0); if (done[3]) dcount++;
        step(4'b0000, 4'b1000, 1'b0); if (done[3]) dcount++;
        step(4'b0000, 4'b0000, 1'b0); if (done[3]) dcount++;
        check("t4_req_held", 32'(req), 32'h8);
        for (int b = 0; b < 3; b++) begin
            step(4'b0000, 4'b1000, 1'b0);
            if (done[3]) dcount++;
        end
        check("t4_no_early_done", 32'(dcount), 32'd0);
        step(4'b0000, 4'b1000, 1'b0);
        check("t4_done", 32'(done), 32'h8);
        check("t4_req",  32'(req),  32'h0);
        step(4'b0000, 4'b0000, 1'b0);

        // 5: spurious grant and clear priority
        step(4'b0000, 4'b0100, 1'b0);
        check("t5_spur_set", 32'(spurious_err), 32'h4);
        step(4'b0000, 4'b0000, 1'b1);
        check("t5_spur_clr", 32'(spurious_err), 32'h0);
        step(4'b0000, 4'b0100, 1'b1);
        check("t5_spur_wins", 32'(spurious_err), 32'h4);
        step(4'b0000, 4'b0000, 1'b1);
        check("t5_spur_clr2", 32'(spurious_err), 32'h0);

        // 6: bench acts as the round-robin arbiter
        step(4'b1111, 4'b0000, 1'b0);
        check("t6_req_all", 32'(req), 32'hf);
        ptr = 0;
        for (int n = 0; n < 4; n++) begin
            owner = -1;
            for (int k = 0; k < 4; k++) begin
                if (owner < 0 && req[(ptr + k) % 4]) owner = (ptr + k) % 4;
            end
            check("t6_order", 32'(owner), 32'(n));
            if (owner < 0) owner = n;
            for (int b = 0; b < 4; b++) begin
                step(4'b0000, 4'(1 << owner), 1'b0);
                check("t6_done", 32'(done), (b == 3) ? 32'(1 << owner) : 32'h0);
            end
            ptr = (owner + 1) % 4;
        end
        check("t6_req_end",  32'(req),          32'h0);
        check("t6_spur_end", 32'(spurious_err), 32'h0);

        // reset mid-burst
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);
        reset = 1'b1;
        step(4'b1111, 4'b0001, 1'b0);
        check_all_zero("t6_reset");
        reset = 1'b0;
        step(4'b0000, 4'b0000, 1'b0);
        check_all_zero("t6_post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
